// File: rtl/gate_test_pkg.sv
// Shared types and default parameters for the gate-library response compactor.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } misr_state_t;

    localparam int RESP_W_DEF = 10;
    localparam int SIG_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;
    localparam logic [15:0] POLY_DEF = 16'h1021;

endpackage

// File: rtl/gate_misr_step.sv
// One MISR update: shift left, apply feedback polynomial when the MSB falls
// out, then fold in the zero-extended response vector. Purely combinational
// so the same step can serve as an LFSR model when resp_data is tied to zero.
module gate_misr_step #(
    parameter int RESP_W = 10,
    parameter int SIG_W  = 16
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  poly,
    output logic [SIG_W-1:0]  sig_next
);

    logic [SIG_W-1:0] fb_s;
    logic [SIG_W-1:0] resp_ext_s;

    assign fb_s       = sig[SIG_W-1] ? poly : {SIG_W{1'b0}};
    assign resp_ext_s = {{(SIG_W-RESP_W){1'b0}}, resp_data};
    assign sig_next   = {sig[SIG_W-2:0], 1'b0} ^ fb_s ^ resp_ext_s;

endmodule

// File: rtl/gate_response_misr.sv
// Response compactor: folds one gate-model output vector per accepted beat
// into a MISR and, after num_patterns beats, compares against the golden
// signature. Optional macro MISR_ABORT_EN adds an abort input that ends a
// run early with pass=0.
module gate_response_misr
    import gate_test_pkg::*;
#(
    parameter int RESP_W = RESP_W_DEF,
    parameter int SIG_W  = SIG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter logic [SIG_W-1:0] POLY = POLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  seed,
    input  logic [SIG_W-1:0]  expected,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
`ifdef MISR_ABORT_EN
    input  logic              abort,
`endif
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    misr_state_t      state_r, state_s;
    logic [SIG_W-1:0] sig_r, sig_s, step_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic [CNT_W-1:0] num_r, num_s;
    logic [SIG_W-1:0] exp_r, exp_s;
    logic             pass_r, pass_s;
    logic             ready_r, busy_r, done_r;
    logic             abort_s;

`ifdef MISR_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    gate_misr_step #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W)
    ) u_step (
        .sig       (sig_r),
        .resp_data (resp_data),
        .poly      (POLY),
        .sig_next  (step_s)
    );

    // Next-state, capture, fold and compare logic.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        cnt_s   = cnt_r;
        num_s   = num_r;
        exp_s   = exp_r;
        pass_s  = pass_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    sig_s  = seed;
                    num_s  = num_patterns;
                    exp_s  = expected;
                    cnt_s  = {CNT_W{1'b0}};
                    pass_s = 1'b0;
                    if (num_patterns == {CNT_W{1'b0}}) begin
                        state_s = CHECK;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (abort_s) begin
                    pass_s  = 1'b0;
                    state_s = DONE;
                end else if (resp_valid) begin
                    sig_s = step_s;
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == num_r) begin
                        state_s = CHECK;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            CHECK: begin
                if (abort_s) begin
                    pass_s = 1'b0;
                end else begin
                    pass_s = (sig_r == exp_r);
                end
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sig_r   <= {SIG_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            num_r   <= {CNT_W{1'b0}};
            exp_r   <= {SIG_W{1'b0}};
            pass_r  <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sig_r   <= sig_s;
            cnt_r   <= cnt_s;
            num_r   <= num_s;
            exp_r   <= exp_s;
            pass_r  <= pass_s;
            ready_r <= (state_s == RUN);
            busy_r  <= (state_s == RUN) || (state_s == CHECK);
            done_r  <= (state_s == DONE);
        end
    end

    assign resp_ready = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign signature  = sig_r;
    assign count      = cnt_r;

endmodule

// File: tb/tb_gate_response_misr.sv
// Directed self-checking bench for gate_response_misr.
module tb_gate_response_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_patterns;
    logic [15:0] seed;
    logic [15:0] expected;
    logic        resp_valid;
    logic [9:0]  resp_data;
    logic        abort;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] count;

    int tests_run    = 0;
    int tests_failed = 0;

    gate_response_misr dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .expected     (expected),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
`ifdef MISR_ABORT_EN
        .abort        (abort),
`endif
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given run parameters.
    task automatic do_start(input logic [15:0] s, input logic [15:0] n, input logic [15:0] e);
        seed = s; num_patterns = n; expected = e; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests_run++;
        if ({resp_ready, busy, done, pass} !== 4'b0000 || signature !== 16'h0000 || count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset: got rdy=%b busy=%b done=%b pass=%b sig=%h cnt=%h want all zero",
                     resp_ready, busy, done, pass, signature, count);
        end
        rst = 1'b0;
        resp_valid = 1'b1; resp_data = 10'h3FF;
        step(); step();
        resp_valid = 1'b0;
        tests_run++;
        if (count !== 16'h0000 || signature !== 16'h0000 || busy !== 1'b0 || resp_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_valid_ignored: got cnt=%h sig=%h busy=%b rdy=%b want 0 0 0 0",
                     count, signature, busy, resp_ready);
        end
    endtask

    task automatic test_single();
        do_start(16'h0000, 16'd1, 16'h0001);
        tests_run++;
        if (busy !== 1'b1 || resp_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_start: got busy=%b rdy=%b done=%b want 1 1 0", busy, resp_ready, done);
        end
        resp_valid = 1'b1; resp_data = 10'h001;
        step();
        resp_valid = 1'b0;
        tests_run++;
        if (signature !== 16'h0001 || count !== 16'd1 || done !== 1'b0 || resp_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_check_cycle: got sig=%h cnt=%h done=%b rdy=%b busy=%b want 0001 1 0 0 1",
                     signature, count, done, resp_ready, busy);
        end
        step();
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
        end
        // Beats offered in DONE must not disturb the frozen result.
        resp_valid = 1'b1; resp_data = 10'h2AA;
        step(); step();
        resp_valid = 1'b0;
        tests_run++;
        if (signature !== 16'h0001 || count !== 16'd1 || done !== 1'b1 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_frozen: got sig=%h cnt=%h done=%b pass=%b want 0001 1 1 1",
                     signature, count, done, pass);
        end
    endtask

    task automatic test_back_to_back();
        do_start(16'h0000, 16'd2, 16'h0004);
        tests_run++;
        if (done !== 1'b0 || pass !== 1'b0 || count !== 16'd0) begin
            tests_failed++;
            $display("FAIL b2b_restart: got done=%b pass=%b cnt=%h want 0 0 0", done, pass, count);
        end
        resp_valid = 1'b1; resp_data = 10'h001;
        step();
        tests_run++;
        if (signature !== 16'h0001 || count !== 16'd1 || resp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_beat1: got sig=%h cnt=%h rdy=%b want 0001 1 1", signature, count, resp_ready);
        end
        step();
        resp_valid = 1'b0;
        tests_run++;
        if (signature !== 16'h0003 || count !== 16'd2) begin
            tests_failed++;
            $display("FAIL b2b_beat2: got sig=%h cnt=%h want 0003 2", signature, count);
        end
        step();
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_result: got done=%b pass=%b want 1 0", done, pass);
        end
    endtask

    task automatic test_poly();
        do_start(16'h8000, 16'd1, 16'h1021);
        resp_valid = 1'b1; resp_data = 10'h000;
        step();
        resp_valid = 1'b0;
        step();
        tests_run++;
        if (signature !== 16'h1021 || done !== 1'b1 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL poly_feedback: got sig=%h done=%b pass=%b want 1021 1 1", signature, done, pass);
        end
    endtask

    task automatic test_zero_patterns();
        resp_valid = 1'b1; resp_data = 10'h155;
        do_start(16'hBEEF, 16'd0, 16'hBEEF);
        tests_run++;
        if (resp_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || signature !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL zero_check_cycle: got rdy=%b busy=%b done=%b sig=%h want 0 1 0 beef",
                     resp_ready, busy, done, signature);
        end
        step();
        resp_valid = 1'b0;
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || count !== 16'd0 || resp_ready !== 1'b0 || signature !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL zero_done: got done=%b pass=%b cnt=%h rdy=%b sig=%h want 1 1 0 0 beef",
                     done, pass, count, resp_ready, signature);
        end
    endtask

    task automatic test_gaps_and_reset();
        do_start(16'h0000, 16'd4, 16'h0000);
        resp_valid = 1'b1; resp_data = 10'h005;
        step();
        resp_valid = 1'b0;
        step(); step();
        tests_run++;
        if (count !== 16'd1 || signature !== 16'h0005 || resp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_hold: got cnt=%h sig=%h rdy=%b want 1 0005 1", count, signature, resp_ready);
        end
        // start during RUN must be ignored; the beat still folds into 0x0005.
        start = 1'b1; seed = 16'h1234; num_patterns = 16'd1;
        resp_valid = 1'b1; resp_data = 10'h003;
        step();
        start = 1'b0; resp_valid = 1'b0;
        tests_run++;
        if (count !== 16'd2 || signature !== 16'h0009 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_in_run: got cnt=%h sig=%h busy=%b done=%b want 2 0009 1 0",
                     count, signature, busy, done);
        end
        // Asynchronous reset: outputs clear without waiting for an edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({resp_ready, busy, done, pass} !== 4'b0000 || signature !== 16'h0000 || count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: got rdy=%b busy=%b done=%b pass=%b sig=%h cnt=%h want all zero",
                     resp_ready, busy, done, pass, signature, count);
        end
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || resp_ready !== 1'b0 || count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy=%b rdy=%b cnt=%h want 0 0 0", busy, resp_ready, count);
        end
    endtask

`ifdef MISR_ABORT_EN
    task automatic test_abort();
        do_start(16'h0000, 16'd5, 16'h0000);
        resp_valid = 1'b1; resp_data = 10'h001;
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0; resp_valid = 1'b0;
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b0 || count !== 16'd2 || signature !== 16'h0003 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: got done=%b pass=%b cnt=%h sig=%h busy=%b want 1 0 2 0003 0",
                     done, pass, count, signature, busy);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; num_patterns = 16'd0; seed = 16'h0000; expected = 16'h0000;
        resp_valid = 1'b0; resp_data = 10'h000; abort = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_poly();
        test_zero_patterns();
        test_gaps_and_reset();
`ifdef MISR_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
